// File: rtl/udb_monitor_pkg.sv
// Shared encodings for the up/down/load counter monitor: FSM state codes and step classes.
package udb_monitor_pkg;

    typedef enum logic [1:0] {
        ACQ  = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } udbState_e;

    typedef enum logic [1:0] {
        STEP_UP   = 2'd0,
        STEP_DOWN = 2'd1,
        STEP_HOLD = 2'd2,
        STEP_JUMP = 2'd3
    } stepClass_e;

    function automatic logic isUnitStep(input stepClass_e step);
        return (step == STEP_UP) || (step == STEP_DOWN);
    endfunction

endpackage

// File: rtl/udb_step_classify.sv
// Combinational step classifier: compares the previous and current observed count and
// reports the step class plus whether the step crossed the max/0 boundary.
module udb_step_classify
    import udb_monitor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] prevVal,
    input  logic [WIDTH-1:0] curVal,
    output stepClass_e       stepClass,
    output logic             wrap
);

    logic [WIDTH-1:0] delta;

    // The subtraction is modulo 2^WIDTH, so max->0 reads as +1 and 0->max as -1.
    always_comb begin
        delta = curVal - prevVal;
        if (delta == WIDTH'(1))
            stepClass = STEP_UP;
        else if (delta == {WIDTH{1'b1}})
            stepClass = STEP_DOWN;
        else if (delta == '0)
            stepClass = STEP_HOLD;
        else
            stepClass = STEP_JUMP;
    end

    assign wrap = ((stepClass == STEP_UP)   && (prevVal == {WIDTH{1'b1}})) ||
                  ((stepClass == STEP_DOWN) && (prevVal == '0));

endmodule

// File: rtl/udb_monitor.sv
// Receive-side observer for the 4-bit up/down/load counter: recovers direction, lock,
// load events and wrap count. Optional hold timeout under UDB_MONITOR_HOLD_TIMEOUT_EN.
module udb_monitor
    import udb_monitor_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int WRAP_W   = 8
`ifdef UDB_MONITOR_HOLD_TIMEOUT_EN
    ,
    parameter int HOLD_MAX = 16
`endif
) (
    input  logic              udb_monitor_clk,
    input  logic              udb_monitor_rst,
    input  logic [WIDTH-1:0]  udb_monitor_in,
    input  logic              udb_monitor_in_valid,
    output logic              udb_monitor_dir,
    output logic              udb_monitor_locked,
    output logic              udb_monitor_dir_chg,
    output logic              udb_monitor_load_det,
    output logic [WRAP_W-1:0] udb_monitor_wrap_cnt,
    output logic              udb_monitor_err,
    output logic              udb_monitor_stall
);

    localparam int RUN_W = $clog2(LOCK_CNT + 1);

    udbState_e        state, nextState;
    logic [WIDTH-1:0] prevVal;
    logic [RUN_W-1:0] run, runInc;
    logic             cand, jumpPend;

    stepClass_e       stepClass;
    logic             stepWrap, unitStep, stepUp;
    logic             sampleSync, sampleLock, syncExtend, syncLock;
    logic             lockReverse, lockWrap, lockLoad, lockJumpErr, holdTimeout;

    logic              dirNxt, lockedNxt, dirChgNxt, loadDetNxt, errNxt, stallNxt;
    logic [WRAP_W-1:0] wrapCntNxt;

    udb_step_classify #(.WIDTH(WIDTH)) uClassify (
        .prevVal   (prevVal),
        .curVal    (udb_monitor_in),
        .stepClass (stepClass),
        .wrap      (stepWrap)
    );

    assign unitStep   = isUnitStep(stepClass);
    assign stepUp     = (stepClass == STEP_UP);
    assign sampleSync = udb_monitor_in_valid && (state == SYNC);
    assign sampleLock = udb_monitor_in_valid && (state == LOCK);

    // A fresh run adopts whatever direction it sees; a mismatched step restarts at 1.
    assign syncExtend  = (run == '0) || (stepUp == cand);
    assign runInc      = syncExtend ? run + 1'b1 : RUN_W'(1);
    assign syncLock    = sampleSync && unitStep && (runInc == RUN_W'(LOCK_CNT));

    assign lockReverse = sampleLock && unitStep && (stepUp != udb_monitor_dir);
    assign lockWrap    = sampleLock && unitStep && (stepUp == udb_monitor_dir) && stepWrap;
    assign lockLoad    = sampleLock && (stepClass == STEP_JUMP) && !jumpPend;
    assign lockJumpErr = sampleLock && (stepClass == STEP_JUMP) && jumpPend;

`ifdef UDB_MONITOR_HOLD_TIMEOUT_EN
    localparam int HOLD_W = $clog2(HOLD_MAX + 1);

    logic [HOLD_W-1:0] holdCnt;

    assign holdTimeout = sampleLock && (stepClass == STEP_HOLD) && (holdCnt == HOLD_W'(HOLD_MAX));

    always_ff @(posedge udb_monitor_clk) begin
        if (udb_monitor_rst) begin
            holdCnt <= '0;
        end else if (udb_monitor_in_valid) begin
            if ((state == LOCK) && (stepClass == STEP_HOLD) && !holdTimeout)
                holdCnt <= holdCnt + 1'b1;
            else
                holdCnt <= '0;
        end
    end
`else
    assign holdTimeout = 1'b0;
`endif

    // NOTE: all registered state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge udb_monitor_clk) begin
        if (udb_monitor_rst)
            state <= ACQ;
        else
            state <= nextState;
    end

    // NOTE: each combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        nextState = state;
        case (state)
            ACQ:     if (udb_monitor_in_valid) nextState = SYNC;
            SYNC:    if (syncLock) nextState = LOCK;
            LOCK:    if (lockJumpErr || holdTimeout) nextState = SYNC;
            default: nextState = ACQ;
        endcase
    end

    always_comb begin
        lockedNxt  = (nextState == LOCK);
        dirNxt     = udb_monitor_dir;
        if (syncLock)
            dirNxt = stepUp;
        else if (lockReverse)
            dirNxt = ~udb_monitor_dir;
        dirChgNxt  = lockReverse;
        loadDetNxt = lockLoad;
        errNxt     = udb_monitor_err || lockJumpErr;
        stallNxt   = holdTimeout;
        wrapCntNxt = udb_monitor_wrap_cnt;
        if (lockWrap && (udb_monitor_wrap_cnt != {WRAP_W{1'b1}}))
            wrapCntNxt = udb_monitor_wrap_cnt + 1'b1;
    end

    always_ff @(posedge udb_monitor_clk) begin
        if (udb_monitor_rst) begin
            prevVal  <= '0;
            run      <= '0;
            cand     <= 1'b0;
            jumpPend <= 1'b0;
        end else if (udb_monitor_in_valid) begin
            prevVal <= udb_monitor_in;
            case (state)
                SYNC: begin
                    if (unitStep) begin
                        run  <= syncLock ? '0 : runInc;
                        cand <= stepUp;
                    end else if (stepClass == STEP_JUMP) begin
                        run <= '0;
                    end
                end
                // Any non-jump sample clears the pending jump; a second jump clears it via the error exit.
                LOCK: begin
                    jumpPend <= lockLoad;
                    run      <= '0;
                end
                default: run <= '0;
            endcase
        end
    end

    always_ff @(posedge udb_monitor_clk) begin
        if (udb_monitor_rst) begin
            udb_monitor_dir      <= 1'b0;
            udb_monitor_locked   <= 1'b0;
            udb_monitor_dir_chg  <= 1'b0;
            udb_monitor_load_det <= 1'b0;
            udb_monitor_wrap_cnt <= '0;
            udb_monitor_err      <= 1'b0;
            udb_monitor_stall    <= 1'b0;
        end else begin
            udb_monitor_dir      <= dirNxt;
            udb_monitor_locked   <= lockedNxt;
            udb_monitor_dir_chg  <= dirChgNxt;
            udb_monitor_load_det <= loadDetNxt;
            udb_monitor_wrap_cnt <= wrapCntNxt;
            udb_monitor_err      <= errNxt;
            udb_monitor_stall    <= stallNxt;
        end
    end

endmodule

// File: tb/tb_udb_monitor.sv
// Directed scoreboard bench for udb_monitor: expectations are queued as each sample is
// driven and checked against the registered outputs one edge later.
module tb_udb_monitor;

    typedef struct packed {
        logic [1:0] state;
        logic       dir;
        logic       locked;
        logic       dirChg;
        logic       loadDet;
        logic [7:0] wrapCnt;
        logic       err;
        logic       stall;
    } expect_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] inData = '0;
    logic       inValid = 1'b0;
    logic       dir, locked, dirChg, loadDet, err, stall;
    logic [7:0] wrapCnt;

    expect_t expQ[$];
    expect_t cur = '0;
    int      tests = 0;
    int      fails = 0;

    always #5 clk = ~clk;

    udb_monitor dut (
        .udb_monitor_clk      (clk),
        .udb_monitor_rst      (rst),
        .udb_monitor_in       (inData),
        .udb_monitor_in_valid (inValid),
        .udb_monitor_dir      (dir),
        .udb_monitor_locked   (locked),
        .udb_monitor_dir_chg  (dirChg),
        .udb_monitor_load_det (loadDet),
        .udb_monitor_wrap_cnt (wrapCnt),
        .udb_monitor_err      (err),
        .udb_monitor_stall    (stall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one sample, queue the expected response, then compare after the next edge.
    task automatic tick(input logic r, input logic v, input logic [3:0] val);
        expect_t e;
        @(negedge clk);
        rst     = r;
        inValid = v;
        inData  = val;
        expQ.push_back(cur);
        cur.dirChg  = 1'b0;
        cur.loadDet = 1'b0;
        cur.stall   = 1'b0;
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard: observed empty queue expected one entry");
        end else begin
            e = expQ.pop_front();
            check("state",    32'(dut.state), 32'(e.state));
            check("dir",      32'(dir),       32'(e.dir));
            check("locked",   32'(locked),    32'(e.locked));
            check("dir_chg",  32'(dirChg),    32'(e.dirChg));
            check("load_det", 32'(loadDet),   32'(e.loadDet));
            check("wrap_cnt", 32'(wrapCnt),   32'(e.wrapCnt));
            check("err",      32'(err),       32'(e.err));
            check("stall",    32'(stall),     32'(e.stall));
        end
    endtask

    initial begin
        // Reset: everything zero, state ACQ
        tick(1'b1, 1'b0, 4'd0);
        tick(1'b1, 1'b0, 4'd0);

        // Count up 0..15,0: lock after sample 3, one wrap
        cur.state = 2'd1;
        tick(1'b0, 1'b1, 4'd0);
        for (int v = 1; v <= 15; v++) begin
            if (v == 3) begin
                cur.locked = 1'b1;
                cur.dir    = 1'b1;
                cur.state  = 2'd2;
            end
            tick(1'b0, 1'b1, 4'(v));
        end
        cur.wrapCnt = 8'd1;
        tick(1'b0, 1'b1, 4'd0);
        for (int v = 1; v <= 7; v++) tick(1'b0, 1'b1, 4'(v));

        // Reversal at 7 -> 6: one-cycle dir_chg, pulse drops on an idle cycle
        cur.dir    = 1'b0;
        cur.dirChg = 1'b1;
        tick(1'b0, 1'b1, 4'd6);
        tick(1'b0, 1'b0, 4'hA);
        tick(1'b0, 1'b1, 4'd5);
        tick(1'b0, 1'b1, 4'd4);
        tick(1'b0, 1'b1, 4'd3);
        tick(1'b0, 1'b1, 4'd2);
        cur.dir    = 1'b1;
        cur.dirChg = 1'b1;
        tick(1'b0, 1'b1, 4'd3);

        // Single load 3 -> 5 while locked up, then normal steps
        cur.loadDet = 1'b1;
        tick(1'b0, 1'b1, 4'd5);
        tick(1'b0, 1'b1, 4'd6);
        tick(1'b0, 1'b1, 4'd7);

        // Walk up through a second wrap to 3, then two jumps -> sticky error
        for (int v = 8; v <= 15; v++) tick(1'b0, 1'b1, 4'(v));
        cur.wrapCnt = 8'd2;
        tick(1'b0, 1'b1, 4'd0);
        tick(1'b0, 1'b1, 4'd1);
        tick(1'b0, 1'b1, 4'd2);
        tick(1'b0, 1'b1, 4'd3);
        cur.loadDet = 1'b1;
        tick(1'b0, 1'b1, 4'd9);
        cur.err    = 1'b1;
        cur.locked = 1'b0;
        cur.state  = 2'd1;
        tick(1'b0, 1'b1, 4'd1);
        tick(1'b0, 1'b1, 4'd2);
        tick(1'b0, 1'b1, 4'd3);
        cur.locked = 1'b1;
        cur.state  = 2'd2;
        tick(1'b0, 1'b1, 4'd4);

        // Invalid cycles change nothing, prev kept at 4
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 4'hF);
        tick(1'b0, 1'b1, 4'd5);

        // Reset overrides a would-be load; idle cycles in ACQ
        cur = '0;
        tick(1'b1, 1'b1, 4'hC);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 4'd7);

        // SYNC: jump clears the run, mismatched steps restart it, lock downward
        cur.state = 2'd1;
        tick(1'b0, 1'b1, 4'd8);
        tick(1'b0, 1'b1, 4'd9);
        tick(1'b0, 1'b1, 4'd10);
        tick(1'b0, 1'b1, 4'd13);
        tick(1'b0, 1'b1, 4'd12);
        tick(1'b0, 1'b1, 4'd13);
        tick(1'b0, 1'b1, 4'd12);
        tick(1'b0, 1'b1, 4'd11);
        cur.locked = 1'b1;
        cur.dir    = 1'b0;
        cur.state  = 2'd2;
        tick(1'b0, 1'b1, 4'd10);

        // A HOLD between two jumps clears the pending jump: two loads, no error
        cur.loadDet = 1'b1;
        tick(1'b0, 1'b1, 4'd3);
        tick(1'b0, 1'b1, 4'd3);
        cur.loadDet = 1'b1;
        tick(1'b0, 1'b1, 4'd7);
        tick(1'b0, 1'b1, 4'd6);
        tick(1'b0, 1'b1, 4'd5);
        tick(1'b0, 1'b1, 4'd4);

        // Down-counting through 256 wraps: wrap_cnt saturates at 255
        for (int n = 0; n < 256 * 16; n++) begin
            if (4'(3 - n) == 4'hF && cur.wrapCnt != 8'hFF) cur.wrapCnt = cur.wrapCnt + 8'd1;
            tick(1'b0, 1'b1, 4'(3 - n));
        end

        // Hold value 4 for 17 valid samples, then one more
        for (int i = 1; i <= 17; i++) begin
`ifdef UDB_MONITOR_HOLD_TIMEOUT_EN
            if (i == 17) begin
                cur.stall  = 1'b1;
                cur.locked = 1'b0;
                cur.state  = 2'd1;
            end
`endif
            tick(1'b0, 1'b1, 4'd4);
        end
        tick(1'b0, 1'b1, 4'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
